// File: rtl/cache_pkg.sv
// Shared definitions for the N-way write-back cache: FSM encoding and width helpers.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_RESPOND   = 3'd4
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Stored line word is {tag, data}; valid/dirty/age live in separate control arrays.
    localparam int DATA_LSB = 0;

    function automatic int tag_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int line_w(input int tag_w, input int data_w);
        return tag_w + data_w;
    endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// True-LRU age update for one set: accessed way -> 0, younger ways age by one.
module cache_lru_ages
    import cache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [WAYS*clog2(WAYS)-1:0] ages_in,
    input  logic [clog2(WAYS)-1:0]      acc_way,
    output logic [WAYS*clog2(WAYS)-1:0] ages_out,
    output logic [clog2(WAYS)-1:0]      lru_way
);

    localparam int AW = clog2(WAYS);

    logic [AW-1:0] old_age;

    always_comb begin
        old_age  = ages_in[acc_way*AW +: AW];
        ages_out = ages_in;
        lru_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == acc_way)
                ages_out[w*AW +: AW] = '0;
            else if (ages_in[w*AW +: AW] < old_age)
                ages_out[w*AW +: AW] = ages_in[w*AW +: AW] + 1'b1;
            if (ages_in[w*AW +: AW] == AW'(WAYS-1))
                lru_way = AW'(w);
        end
    end

endmodule

// File: rtl/cache_assoc_nway_wb.sv
// N-way set-associative write-back, write-allocate cache with true-LRU replacement
// and req/ack handshaked memory port (one word per block).
module cache_assoc_nway_wb
    import cache_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 1,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [TAG_W+INDEX_W-1:0] req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     mem_req,
    output logic                     mem_write,
    output logic [TAG_W+INDEX_W-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int SETS   = 1 << INDEX_W;
    localparam int AW     = clog2(WAYS);
    localparam int ADDR_W = TAG_W + INDEX_W;
    localparam int LW     = line_w(TAG_W, DATA_W);
    localparam int TL     = tag_lsb(DATA_W);

    state_t state_q, state_d;

    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [WAYS*AW-1:0] ages_q  [SETS];
    logic [LW-1:0]      line_q  [SETS][WAYS];

    logic              req_wr_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [AW-1:0]     way_q;
    logic              resp_hit_q;
    logic [DATA_W-1:0] resp_rdata_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit, vic_dirty, hit_st, fill_st, fill_ld;
    logic [AW-1:0]      hit_way, victim, lru_way, acc_way, fill_way;
    logic [WAYS*AW-1:0] ages_upd;

    assign idx = req_addr_q[INDEX_W-1:0];
    assign tag = req_addr_q[ADDR_W-1:INDEX_W];

    // Victim preference: lowest-numbered invalid way, otherwise the LRU way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = lru_way;
        for (int w = WAYS-1; w >= 0; w--)
            if (!valid_q[idx][w]) victim = AW'(w);
        for (int w = 0; w < WAYS; w++)
            if (valid_q[idx][w] && line_q[idx][w][TL +: TAG_W] == tag) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
    end

    assign acc_way   = hit ? hit_way : victim;
    assign vic_dirty = valid_q[idx][victim] && dirty_q[idx][victim];
    assign hit_st    = (state_q == ST_LOOKUP) && hit && req_wr_q;
    assign fill_st   = ((state_q == ST_LOOKUP) && !hit && req_wr_q && !vic_dirty) ||
                       ((state_q == ST_WRITEBACK) && mem_ack && req_wr_q);
    assign fill_ld   = (state_q == ST_REFILL) && mem_ack;
    assign fill_way  = (state_q == ST_LOOKUP) ? victim : way_q;

    cache_lru_ages #(.WAYS(WAYS)) u_lru (
        .ages_in  (ages_q[idx]),
        .acc_way  (way_q),
        .ages_out (ages_upd),
        .lru_way  (lru_way)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (req_valid) state_d = ST_LOOKUP;
            ST_LOOKUP:
                if (hit)            state_d = ST_RESPOND;
                else if (vic_dirty) state_d = ST_WRITEBACK;
                else if (!req_wr_q) state_d = ST_REFILL;
                else                state_d = ST_RESPOND;
            ST_WRITEBACK: if (mem_ack) state_d = req_wr_q ? ST_RESPOND : ST_REFILL;
            ST_REFILL:    if (mem_ack) state_d = ST_RESPOND;
            ST_RESPOND:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESPOND);
        resp_hit   = resp_hit_q;
        resp_rdata = resp_rdata_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                mem_addr  = {line_q[idx][way_q][TL +: TAG_W], idx};
                mem_wdata = line_q[idx][way_q][DATA_LSB +: DATA_W];
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = req_addr_q;
            end
            default: ;
        endcase
    end

    // Control state: cleared asynchronously so an abandoned transaction leaves no line behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            way_q        <= '0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    ages_q[s][w*AW +: AW] <= AW'(w);
            end
        end else begin
            state_q <= state_d;
            if (state_q == ST_LOOKUP) begin
                way_q        <= acc_way;
                resp_hit_q   <= hit;
                resp_rdata_q <= req_wr_q ? req_wdata_q : line_q[idx][hit_way][DATA_LSB +: DATA_W];
            end
            if (hit_st)
                dirty_q[idx][hit_way] <= 1'b1;
            if (fill_st || fill_ld) begin
                valid_q[idx][fill_way] <= 1'b1;
                dirty_q[idx][fill_way] <= fill_st;
            end
            if (fill_ld)
                resp_rdata_q <= mem_rdata;
            if (state_q == ST_RESPOND)
                ages_q[idx] <= ages_upd;
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == ST_IDLE && req_valid) begin
            req_wr_q    <= req_write;
            req_addr_q  <= req_addr;
            req_wdata_q <= req_wdata;
        end
        if (hit_st)
            line_q[idx][hit_way][DATA_LSB +: DATA_W] <= req_wdata_q;
        if (fill_st)
            line_q[idx][fill_way] <= {tag, req_wdata_q};
        if (fill_ld)
            line_q[idx][fill_way] <= {tag, mem_rdata};
    end

endmodule
